riscv_stbuf: RTL and testbench

RISCV_STBUF -- requirements
Module: riscv_stbuf

---
 rtl/riscv_stbuf_pkg.sv | 21 ++
 rtl/riscv_stbuf_match.sv | 45 ++++
 rtl/riscv_stbuf.sv | 171 +++++++++++++++++
 tb/tb_riscv_stbuf.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_stbuf_pkg.sv
// Shared types for the RISC-V store buffer: buffered store entry and downstream FSM states.
package riscv_stbuf_pkg;

  // Entries are sized for the widest supported XLEN; narrower builds zero the upper bits.
  localparam int XLEN_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0]   adr;
    logic [XLEN_MAX-1:0]   d;
    logic [XLEN_MAX/8-1:0] be;
    logic [1:0]            prv;
  } stb_entry_t;

endpackage

// File: rtl/riscv_stbuf_match.sv
// Word-address match of a load against all valid store entries; the youngest match decides forwarding.
module riscv_stbuf_match
  import riscv_stbuf_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  stb_entry_t                 entries [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  input  logic [XLEN-1:0]            adr,
  input  logic [XLEN/8-1:0]          be,
  output logic                       hit,
  output logic                       covered,
  output logic [XLEN-1:0]            fwd_d
);

  localparam int PW  = $clog2(DEPTH);
  localparam int OFS = $clog2(XLEN/8);

  logic [PW-1:0] idx;
  logic          unused_bits;

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    hit     = 1'b0;
    covered = 1'b0;
    fwd_d   = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (valid[idx] && (entries[idx].adr[XLEN-1:OFS] == adr[XLEN-1:OFS])) begin
        hit     = 1'b1;
        covered = ((entries[idx].be[XLEN/8-1:0] & be) == be);
        fwd_d   = entries[idx].d[XLEN-1:0];
      end
    end
  end

  always_comb begin
    unused_bits = 1'b0;
    for (int i = 0; i < DEPTH; i++) unused_bits = unused_bits ^ (^entries[i]);
  end

endmodule

// File: rtl/riscv_stbuf.sv
// Store buffer between CPU and cache: buffers stores, forwards covered loads, drains in program order.
//   state    | meaning
//   ST_IDLE  | no downstream access outstanding
//   ST_LOAD  | bypassing load outstanding, waiting cache_ack
//   ST_FLUSH | flush outstanding (buffer already empty), waiting cache_ack
//   ST_DRAIN | head store outstanding, popped on cache_ack
module riscv_stbuf
  import riscv_stbuf_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_flush,
  input  logic [XLEN-1:0]   mem_adr,
  input  logic [XLEN-1:0]   mem_d,
  input  logic [XLEN/8-1:0] mem_be,
  input  logic [1:0]        mem_prv,
  output logic [XLEN-1:0]   mem_q,
  output logic              mem_ack,
  output logic              cache_req,
  output logic              cache_we,
  output logic              cache_flush,
  output logic [XLEN-1:0]   cache_adr,
  output logic [XLEN-1:0]   cache_d,
  output logic [XLEN/8-1:0] cache_be,
  output logic [1:0]        cache_prv,
  input  logic [XLEN-1:0]   cache_q,
  input  logic              cache_ack,
  output logic              buf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  stb_entry_t       entries [DEPTH];
  stb_entry_t       new_entry;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  state_e           state, state_nxt;

  logic            hit, covered;
  logic [XLEN-1:0] fwd_d;
  logic            req_new, st_req, ld_req, fl_req;
  logic            do_push, do_pop, do_fwd;
  logic            issue_load, issue_flush, issue_drain;

  // The ack cycle still shows the old request, so it must not be acted on twice.
  assign req_new   = mem_req & ~mem_ack;
  assign st_req    = req_new & mem_we & ~mem_flush;
  assign ld_req    = req_new & ~mem_we & ~mem_flush;
  assign fl_req    = req_new & mem_flush;
  assign do_push   = st_req & (count != FULL);
  assign do_fwd    = ld_req & hit & covered;
  assign do_pop    = (state == ST_DRAIN) & cache_ack;
  assign buf_empty = (count == '0) & (state == ST_IDLE);

  riscv_stbuf_match #(.XLEN(XLEN), .DEPTH(DEPTH)) u_match (
    .entries (entries),
    .valid   (valid),
    .rd_ptr  (rd_ptr),
    .adr     (mem_adr),
    .be      (mem_be),
    .hit     (hit),
    .covered (covered),
    .fwd_d   (fwd_d)
  );

  always_comb begin
    new_entry                = '0;
    new_entry.adr[XLEN-1:0]  = mem_adr;
    new_entry.d[XLEN-1:0]    = mem_d;
    new_entry.be[XLEN/8-1:0] = mem_be;
    new_entry.prv            = mem_prv;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue_load  = 1'b0;
    issue_flush = 1'b0;
    issue_drain = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ld_req && !hit) begin
          issue_load = 1'b1;
          state_nxt  = ST_LOAD;
        end else if (fl_req && (count == '0)) begin
          issue_flush = 1'b1;
          state_nxt   = ST_FLUSH;
        end else if (count != '0) begin
          issue_drain = 1'b1;
          state_nxt   = ST_DRAIN;
        end
      end
      default: if (cache_ack) state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ack     <= 1'b0;
      mem_q       <= '0;
      cache_req   <= 1'b0;
      cache_we    <= 1'b0;
      cache_flush <= 1'b0;
      cache_adr   <= '0;
      cache_d     <= '0;
      cache_be    <= '0;
      cache_prv   <= '0;
    end else begin
      mem_ack <= do_push | do_fwd;
      if (do_fwd) mem_q <= fwd_d;
      if (cache_ack && (state == ST_LOAD || state == ST_FLUSH)) begin
        mem_ack <= 1'b1;
        if (state == ST_LOAD) mem_q <= cache_q;
      end
      if (cache_ack) cache_req <= 1'b0;
      if (issue_drain) begin
        cache_req   <= 1'b1;
        cache_we    <= 1'b1;
        cache_flush <= 1'b0;
        cache_adr   <= entries[rd_ptr].adr[XLEN-1:0];
        cache_d     <= entries[rd_ptr].d[XLEN-1:0];
        cache_be    <= entries[rd_ptr].be[XLEN/8-1:0];
        cache_prv   <= entries[rd_ptr].prv;
      end else if (issue_load || issue_flush) begin
        cache_req   <= 1'b1;
        cache_we    <= 1'b0;
        cache_flush <= issue_flush;
        cache_adr   <= mem_adr;
        cache_d     <= mem_d;
        cache_be    <= mem_be;
        cache_prv   <= mem_prv;
      end
    end
  end

endmodule

// File: tb/tb_riscv_stbuf.sv
// Self-checking bench for riscv_stbuf: directed scenarios plus random traffic against a program-order memory model.
module tb_riscv_stbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_flush;
  logic [31:0] mem_adr, mem_d, mem_q;
  logic [3:0]  mem_be;
  logic [1:0]  mem_prv;
  logic        mem_ack;
  logic        cache_req, cache_we, cache_flush;
  logic [31:0] cache_adr, cache_d, cache_q;
  logic [3:0]  cache_be;
  logic [1:0]  cache_prv;
  logic        cache_ack;
  logic        buf_empty;

  riscv_stbuf #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_flush(mem_flush),
    .mem_adr(mem_adr), .mem_d(mem_d), .mem_be(mem_be), .mem_prv(mem_prv),
    .mem_q(mem_q), .mem_ack(mem_ack),
    .cache_req(cache_req), .cache_we(cache_we), .cache_flush(cache_flush),
    .cache_adr(cache_adr), .cache_d(cache_d), .cache_be(cache_be), .cache_prv(cache_prv),
    .cache_q(cache_q), .cache_ack(cache_ack), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] d;
    logic [3:0]  be;
    logic [1:0]  prv;
  } st_t;

  int          n_checks = 0;
  int          n_errors = 0;
  st_t         exp_st[$];
  logic [31:0] ref_mem   [int unsigned];
  logic [31:0] cache_mem [int unsigned];
  logic [1:0]  log_kind[$];
  logic [31:0] log_adr[$];
  int          n_load_reqs = 0;
  bit          hold_ack = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  function automatic logic [31:0] cache_rd(input int unsigned w);
    return cache_mem.exists(w) ? cache_mem[w] : 32'h0;
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  // Downstream cache model: random latency, optional ack hold, logs completed accesses.
  initial begin
    bit          armed;
    int          cwait;
    logic [71:0] seen;
    int          n_same;
    armed = 1'b0; cwait = 0; seen = '0;
    cache_ack = 1'b0; cache_q = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        cache_ack = 1'b0;
        armed = 1'b0;
      end else if (cache_ack) begin
        cache_ack = 1'b0;
        armed = 1'b0;
      end else if (cache_req) begin
        if (!armed) begin
          armed = 1'b1;
          cwait = $urandom_range(1, 3);
          seen  = {cache_we, cache_flush, cache_adr, cache_d, cache_be, cache_prv};
          if (cache_flush) check_val("fl_order", exp_st.size(), 0);
          else if (!cache_we) begin
            n_load_reqs++;
            n_same = 0;
            foreach (exp_st[i]) if (exp_st[i].adr[31:2] == cache_adr[31:2]) n_same++;
            check_val("ld_order", n_same, 0);
          end
        end
        if (cwait > 0) cwait--;
        else if (!hold_ack) begin
          check_val("cache_stable", {cache_we, cache_flush, cache_adr, cache_d, cache_be, cache_prv}, seen);
          cache_ack = 1'b1;
          cache_q   = $urandom;
          log_adr.push_back(cache_adr);
          if (cache_flush) log_kind.push_back(2'd2);
          else if (cache_we) begin
            log_kind.push_back(2'd1);
            check_val("st_pending", exp_st.size() != 0, 1);
            if (exp_st.size() != 0) begin
              check_val("st_order", {cache_adr, cache_d, cache_be, cache_prv}, exp_st[0]);
              void'(exp_st.pop_front());
            end
            cache_mem[cache_adr >> 2] = merge(cache_rd(cache_adr >> 2), cache_d, cache_be);
          end else begin
            log_kind.push_back(2'd0);
            cache_q = cache_rd(cache_adr >> 2);
          end
        end
      end
    end
  end

  task automatic start_req(input logic we, input logic fl, input logic [31:0] adr,
                           input logic [31:0] d, input logic [3:0] be, input logic [1:0] prv);
    mem_req = 1'b1; mem_we = we; mem_flush = fl;
    mem_adr = adr; mem_d = d; mem_be = be; mem_prv = prv;
    if (we && !fl) begin
      exp_st.push_back('{adr: adr, d: d, be: be, prv: prv});
      ref_mem[adr >> 2] = merge(ref_rd(adr >> 2), d, be);
    end
  endtask

  task automatic wait_ack(output logic [31:0] q, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_ack && lat < 300);
    check_val("ack_seen", mem_ack, 1);
    q = mem_q;
    mem_req = 1'b0;
    @(posedge clk); #1;
    check_val("ack_pulse", mem_ack, 0);
  endtask

  task automatic cpu_op(input logic we, input logic fl, input logic [31:0] adr, input logic [31:0] d,
                        input logic [3:0] be, input logic [1:0] prv, output logic [31:0] q, output int lat);
    start_req(we, fl, adr, d, be, prv);
    wait_ack(q, lat);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (!buf_empty && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("drain_done", buf_empty, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ack"}, mem_ack, 0);
    check_val({tag, "_creq"}, cache_req, 0);
    check_val({tag, "_empty"}, buf_empty, 1);
    check_val({tag, "_outs"}, {cache_we, cache_flush, cache_adr, cache_d, cache_be, cache_prv, mem_q}, 0);
  endtask

  initial begin
    logic [31:0] q, adr;
    logic [3:0]  be;
    int          lat, nl, r;
    bit          saw;

    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_flush = 1'b0;
    mem_adr = '0; mem_d = '0; mem_be = '0; mem_prv = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    rst = 1'b0;

    // Four stores fill the buffer while the first drain is held; the fifth stalls.
    hold_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_op(1'b1, 1'b0, 32'h100 + 32'(4 * i), $urandom, 4'hF, 2'(i), q, lat);
      check_val("st_lat", lat, 1);
    end
    start_req(1'b1, 1'b0, 32'h110, 32'h5555_AAAA, 4'hF, 2'd3);
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mem_ack) saw = 1'b1;
    end
    check_val("full_stall", saw, 0);
    hold_ack = 1'b0;
    wait_ack(q, lat);
    wait_empty();

    // Fully covered load forwards from the buffer without a cache read.
    hold_ack = 1'b1;
    cpu_op(1'b1, 1'b0, 32'h200, 32'hDEADBEEF, 4'hF, 2'd1, q, lat);
    nl = n_load_reqs;
    cpu_op(1'b0, 1'b0, 32'h200, 32'h0, 4'h3, 2'd1, q, lat);
    check_val("fwd_lat", lat, 1);
    check_val("fwd_data", q, 32'hDEADBEEF);
    check_val("fwd_no_cache", n_load_reqs - nl, 0);
    hold_ack = 1'b0;
    wait_empty();

    // Partially covered load waits for the store to drain, then reads the cache.
    hold_ack = 1'b1;
    cpu_op(1'b1, 1'b0, 32'h300, 32'h0000_00A5, 4'h1, 2'd2, q, lat);
    nl = n_load_reqs;
    start_req(1'b0, 1'b0, 32'h300, 32'h0, 4'hF, 2'd2);
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_ack) saw = 1'b1;
    end
    check_val("part_stall", saw, 0);
    hold_ack = 1'b0;
    wait_ack(q, lat);
    check_val("part_data", q, ref_rd(32'h300 >> 2));
    check_val("part_cache_rd", n_load_reqs - nl, 1);
    wait_empty();

    // Non-matching load overtakes the still-buffered second store.
    log_kind.delete(); log_adr.delete();
    hold_ack = 1'b1;
    cpu_op(1'b1, 1'b0, 32'h400, 32'h1111_1111, 4'hF, 2'd0, q, lat);
    cpu_op(1'b1, 1'b0, 32'h404, 32'h2222_2222, 4'hF, 2'd0, q, lat);
    start_req(1'b0, 1'b0, 32'h500, 32'h0, 4'hF, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    hold_ack = 1'b0;
    wait_ack(q, lat);
    wait_empty();
    check_val("byp_ord0", {log_kind[0], log_adr[0]}, {2'd1, 32'h400});
    check_val("byp_ord1", {log_kind[1], log_adr[1]}, {2'd0, 32'h500});
    check_val("byp_ord2", {log_kind[2], log_adr[2]}, {2'd1, 32'h404});

    // Flush waits behind three stores.
    log_kind.delete(); log_adr.delete();
    for (int i = 0; i < 3; i++) cpu_op(1'b1, 1'b0, 32'h600 + 32'(4 * i), $urandom, 4'hF, 2'd3, q, lat);
    cpu_op(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 2'd3, q, lat);
    check_val("flush_pos", {log_kind.size(), log_kind[3]}, {32'd4, 2'd2});

    // Reset mid-drain discards buffered stores and the held access.
    hold_ack = 1'b1;
    cpu_op(1'b1, 1'b0, 32'h700, 32'h7777_7777, 4'hF, 2'd1, q, lat);
    cpu_op(1'b1, 1'b0, 32'h704, 32'h7878_7878, 4'hF, 2'd1, q, lat);
    repeat (2) @(posedge clk);
    #1;
    check_val("drain_busy", cache_req, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst1");
    rst = 1'b0;
    hold_ack = 1'b0;
    exp_st.delete();
    ref_mem = cache_mem;
    nl = log_kind.size();
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_no_drain", {buf_empty, 32'(log_kind.size())}, {1'b1, 32'(nl)});

    // Random traffic over a few words with mixed byte enables.
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 99);
      adr = 32'h1000 + 32'($urandom_range(0, 5) << 2) + 32'($urandom_range(0, 3));
      be  = 4'($urandom_range(1, 15));
      if (r < 60) cpu_op(1'b1, 1'b0, adr, $urandom, be, 2'($urandom_range(0, 3)), q, lat);
      else if (r < 95) begin
        cpu_op(1'b0, 1'b0, adr, $urandom, be, 2'($urandom_range(0, 3)), q, lat);
        check_val("rnd_ld", q & be_mask(be), ref_rd(adr >> 2) & be_mask(be));
      end else cpu_op(1'b0, 1'b1, adr, 32'h0, be, 2'd0, q, lat);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    wait_empty();
    check_val("all_drained", exp_st.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
